// File: rtl/ppu_pkg.sv
// Shared PPU constants and types for the OAM port and its RAM.
// attr_mask() is used only when OAM_ATTR_MASK_EN is defined.
package ppu_pkg;

  localparam logic [2:0] REG_OAMADDR   = 3'd3;
  localparam logic [2:0] REG_OAMDATA   = 3'd4;
  localparam logic [7:0] OAM_ATTR_MASK = 8'hE3;

  typedef logic [7:0] oam_addr_t;

  // Attribute bytes (addr[1:0]==2'b10) have no storage for bits 4:2.
  function automatic logic [7:0] attr_mask(input logic [1:0] lsb, input logic [7:0] d);
    return (lsb == 2'b10) ? (d & OAM_ATTR_MASK) : d;
  endfunction

endpackage

// File: rtl/oam_ram.sv
// OAM storage: DEPTH x 8 array, one write port, two registered read ports.
// Reads return the pre-write contents when a write hits the same address.
module oam_ram
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_a_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [7:0]    rdata_a_o,
  input  logic          re_b_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [7:0]    rdata_b_o
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_a_q;
  logic [7:0] rdata_b_q;

  // Contents survive reset; the write enable is gated upstream.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (re_a_i) rdata_a_q <= mem[raddr_a_i];
      if (re_b_i) rdata_b_q <= mem[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/oam_port.sv
// PPU OAM access controller: $2003/$2004 decode, OAMADDR, DMA/CPU write
// arbitration and renderer reads. Optional macro: OAM_ATTR_MASK_EN.
module oam_port
  import ppu_pkg::*;
#(
  parameter int unsigned OAM_DEPTH = 256,
  parameter int unsigned ADDR_W    = $clog2(OAM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_sel,
  input  logic [2:0]        reg_idx,
  input  logic              bus_wr,
  input  logic [7:0]        bus_data,
  output logic [7:0]        cpu_rd_data,
  input  logic              dma_en,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_data,
  input  logic              rendering,
  input  logic              rend_rd,
  input  logic [ADDR_W-1:0] rend_addr,
  output logic [7:0]        rend_data,
  output logic [ADDR_W-1:0] oamaddr
);

  logic              wr_addr;
  logic              wr_data;
  logic              rd_data;
  logic [ADDR_W-1:0] oamaddr_q;
  logic [ADDR_W-1:0] oamaddr_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata_raw;
  logic [7:0]        wdata;

  assign wr_addr = reg_sel & ~bus_wr & (reg_idx == REG_OAMADDR);
  assign wr_data = reg_sel & ~bus_wr & (reg_idx == REG_OAMDATA);
  assign rd_data = reg_sel &  bus_wr & (reg_idx == REG_OAMDATA);

  always_comb begin
    oamaddr_d = oamaddr_q;
    if (wr_addr)
      oamaddr_d = ADDR_W'(bus_data);
    else if (wr_data)
      oamaddr_d = oamaddr_q + (rendering ? ADDR_W'(4) : ADDR_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) oamaddr_q <= '0;
    else       oamaddr_q <= oamaddr_d;
  end

  // DMA wins the single write port; a losing CPU write still bumps OAMADDR.
  always_comb begin
    we        = 1'b0;
    waddr     = oamaddr_q;
    wdata_raw = bus_data;
    if (!reset) begin
      if (dma_en) begin
        we        = 1'b1;
        waddr     = dma_addr;
        wdata_raw = dma_data;
      end else if (wr_data && !rendering) begin
        we = 1'b1;
      end
    end
  end

`ifdef OAM_ATTR_MASK_EN
  assign wdata = attr_mask(waddr[1:0], wdata_raw);
`else
  assign wdata = wdata_raw;
`endif

  oam_ram #(
    .DEPTH (OAM_DEPTH),
    .AW    (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .re_a_i    (rd_data),
    .raddr_a_i (oamaddr_q),
    .rdata_a_o (cpu_rd_data),
    .re_b_i    (rend_rd),
    .raddr_b_i (rend_addr),
    .rdata_b_o (rend_data)
  );

  assign oamaddr = oamaddr_q;

endmodule
